// File: rtl/steelhorse_pkg.sv
// Shared types and constants for the Steelhorse transmit scheduler.
package steelhorse_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        ARM        = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4,
        DONE       = 3'd5,
        ABORT      = 3'd6
    } txq_state_e;

    localparam logic [9:0] LEN_REG  = 10'h00a;
    localparam logic [9:0] IDLE_REG = 10'h009;

    localparam int LEN_W_DFLT = 16;
    typedef logic [LEN_W_DFLT-1:0] txq_len_t;

    // Timer width able to hold (larger timeout - 1).
    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 32'sd1) ? $clog2(m) : 32'sd1;
    endfunction

endpackage

// File: rtl/steelhorse_txq_fifo.sv
// Descriptor FIFO with occupancy count; accepts a push into a full FIFO when a pop happens in the same cycle.
module steelhorse_txq_fifo
    import steelhorse_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic [LEN_W-1:0]       push_len,
    input  logic                   pop,
    output logic [LEN_W-1:0]       head_len,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [LEN_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == FULL_CNT);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head_len  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Descriptor storage; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge CLK) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_len;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/steelhorse_txq.sv
// Transmit scheduler sequencing the Steelhorse MAC length/RUN/BUSY handshake per queued frame.
// Optional STEELHORSE_TXQ_STATS_EN adds STAT_SENT/STAT_TMO frame counters.
module steelhorse_txq
    import steelhorse_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter int         LEN_W     = 16,
    parameter int         START_TMO = 64,
    parameter int         DONE_TMO  = 4096,
    parameter logic [9:0] LEN_REG   = steelhorse_pkg::LEN_REG,
    parameter logic [9:0] IDLE_REG  = steelhorse_pkg::IDLE_REG
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [LEN_W-1:0]       DESC_LEN,
    input  logic                   DESC_VALID,
    output logic                   DESC_READY,
    output logic [9:0]             MAC_REG_ADDR,
    output logic [LEN_W-1:0]       MAC_REG_DATA,
    output logic                   MAC_RUN,
    input  logic                   MAC_BUSY,
    output logic                   TX_DONE,
    output logic                   TX_ERR,
    output logic [$clog2(DEPTH):0] QCOUNT,
    input  logic                   ENABLE
`ifdef STEELHORSE_TXQ_STATS_EN
    ,
    output logic [15:0]            STAT_SENT,
    output logic [15:0]            STAT_TMO
`endif
);
    localparam int TMR_W = tmr_width(START_TMO, DONE_TMO);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TMO - 1);
    localparam logic [TMR_W-1:0] DONE_LAST  = TMR_W'(DONE_TMO - 1);

    txq_state_e       state_r;
    logic [TMR_W-1:0] timer_r;
    logic [9:0]       addr_r;
    logic [LEN_W-1:0] data_r;
    logic             run_r;
    logic             done_r;
    logic             err_r;
    logic             pop_s;
    logic             push_s;
    logic             full_s;
    logic             empty_s;
    logic [LEN_W-1:0] head_len_s;

    assign pop_s      = (state_r == DONE) || (state_r == ABORT);
    assign DESC_READY = !full_s || pop_s;
    assign push_s     = DESC_VALID && DESC_READY;

    steelhorse_txq_fifo #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (push_s),
        .push_len (DESC_LEN),
        .pop      (pop_s),
        .head_len (head_len_s),
        .full     (full_s),
        .empty    (empty_s),
        .count    (QCOUNT)
    );

    // Frame sequencer; MAC pins and pulses are registered alongside the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
            timer_r <= '0;
            addr_r  <= IDLE_REG;
            data_r  <= '0;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ENABLE && !empty_s && !MAC_BUSY) begin
                        // Zero-length frames complete without touching the MAC.
                        if (head_len_s == '0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= LOAD;
                            addr_r  <= LEN_REG;
                            data_r  <= head_len_s;
                        end
                    end
                end
                LOAD: begin
                    state_r <= ARM;
                    addr_r  <= IDLE_REG;
                    run_r   <= 1'b1;
                end
                ARM: begin
                    state_r <= WAIT_START;
                    timer_r <= '0;
                end
                WAIT_START: begin
                    if (MAC_BUSY) begin
                        state_r <= WAIT_DONE;
                        run_r   <= 1'b0;
                        timer_r <= '0;
                    end else if (timer_r == START_LAST) begin
                        state_r <= ABORT;
                        run_r   <= 1'b0;
                        err_r   <= 1'b1;
                    end else if (timer_r != '1) begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!MAC_BUSY) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else if (timer_r == DONE_LAST) begin
                        state_r <= ABORT;
                        err_r   <= 1'b1;
                    end else if (timer_r != '1) begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                ABORT: begin
                    state_r <= IDLE;
                    run_r   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    run_r   <= 1'b0;
                    addr_r  <= IDLE_REG;
                end
            endcase
        end
    end

    assign MAC_REG_ADDR = addr_r;
    assign MAC_REG_DATA = data_r;
    assign MAC_RUN      = run_r;
    assign TX_DONE      = done_r;
    assign TX_ERR       = err_r;

`ifdef STEELHORSE_TXQ_STATS_EN
    logic [15:0] sent_r;
    logic [15:0] tmo_r;

    // Free-running wrap-around frame counters.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sent_r <= 16'd0;
            tmo_r  <= 16'd0;
        end else begin
            if (done_r) begin
                sent_r <= sent_r + 16'd1;
            end
            if (err_r) begin
                tmo_r <= tmo_r + 16'd1;
            end
        end
    end

    assign STAT_SENT = sent_r;
    assign STAT_TMO  = tmo_r;
`endif

endmodule
